// File: rtl/spi_shared_master.sv
// Round-robin SPI master shared by NUM_CH clients: optional command phase, then read phase.
// Define SPI_MODE3_EN for CPOL=1/CPHA=1 (SCLK idles high); the default build is mode 0.
module spi_shared_master #(
  parameter int NUM_CH  = 2,
  parameter int CMD_W   = 32,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH-1:0]       req_cmd_en,
  input  logic [NUM_CH*CMD_W-1:0] req_cmd,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NUM_CH-1:0]       cs_n
);

  localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAXW = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int EW   = $clog2(2 * MAXW);

  localparam logic [DVW-1:0] DIV_MAX   = DVW'(CLK_DIV - 1);
  localparam logic [EW-1:0]  CMD_LAST  = EW'(2 * CMD_W - 1);
  localparam logic [EW-1:0]  DATA_LAST = EW'(2 * DATA_W - 1);

`ifdef SPI_MODE3_EN
  localparam logic SCLK_IDLE = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, DATA, HOLD, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DVW-1:0]     div_q, div_d;
  logic [EW-1:0]      edge_q, edge_d;
  logic               sclk_q, sclk_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic               cmd_en_q, cmd_en_d;
  logic [CMD_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rsp_q, rsp_d;
  logic [NUM_CH-1:0]  ready_q, ready_d;

  logic [NUM_CH-1:0]  elig;
  logic [GW-1:0]      pick;
  logic               found;
  logic               tick;
  logic               last_edge;

  // The client just completed may still hold req_valid in its ready cycle.
  assign elig = req_valid & ~ready_q;

  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && elig[(int'(last_q) + k) % NUM_CH]) begin
        found = 1'b1;
        pick  = GW'((int'(last_q) + k) % NUM_CH);
      end
    end
  end

  assign tick      = (div_q == DIV_MAX);
  assign last_edge = (edge_q == ((state_q == CMD) ? CMD_LAST : DATA_LAST));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cmd_en_d = cmd_en_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rsp_d    = rsp_q;
    ready_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          cmd_en_d = req_cmd_en[pick];
          tx_d     = req_cmd[int'(pick)*CMD_W +: CMD_W];
          div_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          div_d   = '0;
          edge_d  = '0;
          state_d = cmd_en_q ? CMD : DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      CMD, DATA: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (!sclk_q && state_q == DATA) begin
            rx_d = {rx_q[DATA_W-2:0], miso};
          end
          // Mode 3 opens on a falling edge that must keep the MSB in place.
          if (sclk_q && edge_q != '0 && state_q == CMD) begin
            tx_d = {tx_q[CMD_W-2:0], 1'b0};
          end
          if (last_edge) begin
            edge_d  = '0;
            state_d = (state_q == CMD) ? DATA : HOLD;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        rsp_d            = rx_q;
        ready_d[grant_q] = 1'b1;
        last_d           = grant_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      div_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= SCLK_IDLE;
      grant_q  <= '0;
      last_q   <= GW'(NUM_CH - 1);
      cmd_en_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rsp_q    <= '0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cmd_en_q <= cmd_en_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rsp_q    <= rsp_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    cs_n = '1;
    if (state_q inside {SETUP, CMD, DATA, HOLD}) begin
      cs_n[grant_q] = 1'b0;
    end
  end

  assign mosi      = cmd_en_q & (state_q == SETUP || state_q == CMD)
                   & tx_q[CMD_W-1];
  assign sclk      = sclk_q;
  assign req_ready = ready_q;
  assign rsp_data  = rsp_q;

endmodule
